dense_layer_engine: RTL and testbench

Parametrised fully-connected layer engine: NUM_NEURONS parallel MAC lanes with per-lane bias add, saturation and ReLU, sequenced by an internal FSM over NUM_INPUTS input activations.
- Drives the multi-port main memory read interface: one x port, one weight port per lane, one bias port per lane.
- Returns a full output vector through a valid/ready handshake.
- Replaces the single-neuron datapath plus external controller pairing, and adds multi-lane operation, back-pressure and saturation.

---
 rtl/nn_pkg.sv | 27 ++
 rtl/dense_layer_engine_mac_lane.sv | 87 ++++++++
 rtl/dense_layer_engine.sv | 185 ++++++++++++++++++
 tb/tb_dense_layer_engine.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the dense layer engine:
//   - default word, fraction and accumulator widths
//   - controller state encoding
//   - idx_w(): bit width needed to index n items (never less than 1)
// No ports.
// -----------------------------------------------------------------------------
package nn_pkg;

  localparam int NN_DATA_W    = 32;
  localparam int NN_FRAC_BITS = 16;
  localparam int NN_ACC_W     = 48;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_BIAS  = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dense_layer_engine_mac_lane.sv
// -----------------------------------------------------------------------------
// mac_lane
// One output neuron: fixed-point multiply, arithmetic rescale, accumulate,
// bias add, saturation to the signed DATA_W range and ReLU.
// Ports:
//   clock    rising-edge clock
//   rst      synchronous active-low reset (clears the accumulator)
//   clear    zero the accumulator (start of an inference)
//   acc_en   x_data/w_data carry a valid operand pair this cycle
//   bias_en  b_data carries this lane's bias this cycle
//   finish   present the final activation on res (0 otherwise)
//   x_data   signed activation
//   w_data   signed weight
//   b_data   signed bias
//   res      ReLU(saturate(acc + bias)), combinational, valid while finish=1
// -----------------------------------------------------------------------------
module mac_lane
  import nn_pkg::*;
#(
  parameter int DATA_W    = NN_DATA_W,
  parameter int FRAC_BITS = NN_FRAC_BITS,
  parameter int ACC_W     = NN_ACC_W
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     acc_en,
  input  logic                     bias_en,
  input  logic                     finish,
  input  logic signed [DATA_W-1:0] x_data,
  input  logic signed [DATA_W-1:0] w_data,
  input  logic signed [DATA_W-1:0] b_data,
  output logic signed [DATA_W-1:0] res
);

  localparam int PROD_W = 2 * DATA_W;
  // One extra bit so acc + bias can never wrap before saturation.
  localparam int SUM_W  = ACC_W + 1;

  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [SUM_W-1:0] v);
    logic signed [DATA_W-1:0] r;
    if (v > SAT_MAX)
      r = {1'b0, {(DATA_W-1){1'b1}}};
    else if (v < SAT_MIN)
      r = {1'b1, {(DATA_W-1){1'b0}}};
    else
      r = v[DATA_W-1:0];
    return r;
  endfunction

  function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? '0 : v;
  endfunction

  logic signed [PROD_W-1:0] prod_p1;
  logic signed [ACC_W-1:0]  acc_p2;
  logic signed [DATA_W-1:0] bias_p2;
  logic signed [SUM_W-1:0]  sum_p2;

  // ---- p1: operands returned by memory, full-precision signed product ----
  assign prod_p1 = PROD_W'(x_data) * PROD_W'(w_data);

  // ---- p2: rescaled product accumulated, wrapping at ACC_W ----
  always_ff @(posedge clock) begin
    if (!rst)
      acc_p2 <= '0;
    else if (clear)
      acc_p2 <= '0;
    else if (acc_en)
      acc_p2 <= acc_p2 + ACC_W'(prod_p1 >>> FRAC_BITS);
  end

  always_ff @(posedge clock) begin
    if (bias_en)
      bias_p2 <= b_data;
  end

  // ---- p3: bias add, clamp, ReLU; registered by the top ----
  assign sum_p2 = SUM_W'(acc_p2) + SUM_W'(bias_p2);
  assign res    = finish ? relu(saturate(sum_p2)) : '0;

endmodule

// File: rtl/dense_layer_engine.sv
// -----------------------------------------------------------------------------
// dense_layer_engine
// Fully-connected layer: NUM_NEURONS parallel MAC lanes walk NUM_INPUTS
// activations read from main memory, add per-lane bias, saturate, apply ReLU
// and return the whole vector through a valid/ready handshake.
// Optional build macro: ARGMAX_EN -- when defined, class_idx carries the index
// of the largest output lane (ties to the lowest index); otherwise it is 0.
// Ports:
//   clock      rising-edge clock
//   rst        synchronous active-low reset, aborts any inference
//   start      request an inference (accepted in IDLE only)
//   busy       high whenever not IDLE
//   rd_en      memory read enable (asserted while fetching)
//   x_addr     activation address
//   w_addr     per-lane weight address, lane n at [n*ADDR_W +: ADDR_W]
//   b_addr     per-lane bias address, lane n at [n*ADDR_W +: ADDR_W]
//   x_data     activation read data (1-cycle latency)
//   w_data     per-lane weight read data (1-cycle latency)
//   b_data     per-lane bias read data (1-cycle latency)
//   out_valid  result vector valid
//   out_ready  consumer accepts the result
//   out_data   ReLU outputs, lane n at [n*DATA_W +: DATA_W]
//   class_idx  argmax lane (0 unless ARGMAX_EN)
// -----------------------------------------------------------------------------
module dense_layer_engine
  import nn_pkg::*;
#(
  parameter int NUM_NEURONS = 10,
  parameter int NUM_INPUTS  = 784,
  parameter int DATA_W      = NN_DATA_W,
  parameter int FRAC_BITS   = NN_FRAC_BITS,
  parameter int ACC_W       = NN_ACC_W,
  parameter int ADDR_W      = 16,
  parameter int X_BASE      = 0,
  parameter int W_BASE      = 1024,
  parameter int B_BASE      = 16384
) (
  input  logic                             clock,
  input  logic                             rst,
  input  logic                             start,
  output logic                             busy,
  output logic                             rd_en,
  output logic [ADDR_W-1:0]                x_addr,
  output logic [NUM_NEURONS*ADDR_W-1:0]    w_addr,
  output logic [NUM_NEURONS*ADDR_W-1:0]    b_addr,
  input  logic signed [DATA_W-1:0]         x_data,
  input  logic [NUM_NEURONS*DATA_W-1:0]    w_data,
  input  logic [NUM_NEURONS*DATA_W-1:0]    b_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_NEURONS*DATA_W-1:0]    out_data,
  output logic [$clog2(NUM_NEURONS)-1:0]   class_idx
);

  localparam int              K_W    = idx_w(NUM_INPUTS);
  localparam logic [K_W-1:0]  K_LAST = K_W'(NUM_INPUTS - 1);

  state_t                   state;
  logic [K_W-1:0]           k;
  logic                     vld_p1;
  logic                     first_p1;
  logic                     clear;
  logic                     finish;
  logic signed [DATA_W-1:0] lane_res [NUM_NEURONS];

  assign clear  = (state == ST_IDLE) && start;
  assign finish = (state == ST_BIAS);

  // ---- p0: controller issues addresses; rd_en is the issue-stage valid ----
  always_ff @(posedge clock) begin
    if (!rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      rd_en     <= 1'b0;
      out_valid <= 1'b0;
      k         <= '0;
      x_addr    <= '0;
      w_addr    <= '0;
      b_addr    <= '0;
      vld_p1    <= 1'b0;
      first_p1  <= 1'b0;
    end else begin
      vld_p1   <= rd_en;
      first_p1 <= rd_en && (k == '0);
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_FETCH;
            busy   <= 1'b1;
            rd_en  <= 1'b1;
            k      <= '0;
            x_addr <= ADDR_W'(X_BASE);
            for (int n = 0; n < NUM_NEURONS; n++) begin
              w_addr[n*ADDR_W +: ADDR_W] <= ADDR_W'(W_BASE + n * NUM_INPUTS);
              b_addr[n*ADDR_W +: ADDR_W] <= ADDR_W'(B_BASE + n);
            end
          end
        end
        ST_FETCH: begin
          if (k == K_LAST) begin
            rd_en <= 1'b0;
            state <= ST_DRAIN;
          end else begin
            k      <= k + K_W'(1);
            x_addr <= x_addr + ADDR_W'(1);
            for (int n = 0; n < NUM_NEURONS; n++)
              w_addr[n*ADDR_W +: ADDR_W] <= w_addr[n*ADDR_W +: ADDR_W] + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          state <= ST_BIAS;
        end
        ST_BIAS: begin
          state     <= ST_OUT;
          out_valid <= 1'b1;
        end
        ST_OUT: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---- p1/p2: per-lane multiply-accumulate ----
  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_lane
    mac_lane #(
      .DATA_W    (DATA_W),
      .FRAC_BITS (FRAC_BITS),
      .ACC_W     (ACC_W)
    ) u_lane (
      .clock   (clock),
      .rst     (rst),
      .clear   (clear),
      .acc_en  (vld_p1),
      .bias_en (first_p1),
      .finish  (finish),
      .x_data  (x_data),
      .w_data  ($signed(w_data[n*DATA_W +: DATA_W])),
      .b_data  ($signed(b_data[n*DATA_W +: DATA_W])),
      .res     (lane_res[n])
    );
  end

  // ---- p3: result vector registered on the BIAS -> OUT edge ----
  always_ff @(posedge clock) begin
    if (!rst) begin
      out_data <= '0;
    end else if (state == ST_BIAS) begin
      for (int n = 0; n < NUM_NEURONS; n++)
        out_data[n*DATA_W +: DATA_W] <= lane_res[n];
    end
  end

`ifdef ARGMAX_EN
  localparam int IDX_W = $clog2(NUM_NEURONS);

  logic [IDX_W-1:0] best_idx;

  // Strict greater-than keeps the lowest index on ties; all-zero gives 0.
  always_comb begin
    best_idx = '0;
    for (int n = 1; n < NUM_NEURONS; n++) begin
      if (lane_res[n] > lane_res[best_idx])
        best_idx = IDX_W'(n);
    end
  end

  always_ff @(posedge clock) begin
    if (!rst)
      class_idx <= '0;
    else if (state == ST_BIAS)
      class_idx <= best_idx;
  end
`else
  assign class_idx = '0;
`endif

endmodule

// File: tb/tb_dense_layer_engine.sv
// -----------------------------------------------------------------------------
// tb_dense_layer_engine
// Directed bench for dense_layer_engine with 3 lanes x 4 inputs, Q16.16 data.
// A flat word memory answers all read ports with one cycle of latency.
// Expected vectors are hand-computed fixed-point results.
// -----------------------------------------------------------------------------
module tb_dense_layer_engine;

  localparam int NN   = 3;
  localparam int NI   = 4;
  localparam int DW   = 32;
  localparam int AW   = 16;
  localparam int ACCW = 56;
  localparam int XB   = 0;
  localparam int WB   = 1024;
  localparam int BB   = 16384;
  localparam int MEMW = 16400;

  localparam logic [NN*DW-1:0] EXP_BASIC = {32'h0002_0000, 32'h0000_0000, 32'h0002_0000};
  localparam logic [NN*DW-1:0] EXP_SAT   = {32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
  localparam logic [NN*DW-1:0] EXP_MIX   = {32'h0006_8000, 32'h0000_0000, 32'h0004_8000};
`ifdef ARGMAX_EN
  localparam logic [1:0] EXP_MIX_IDX = 2'd2;
`else
  localparam logic [1:0] EXP_MIX_IDX = 2'd0;
`endif

  logic              clock     = 1'b0;
  logic              rst       = 1'b0;
  logic              start     = 1'b0;
  logic              out_ready = 1'b0;
  logic              busy;
  logic              rd_en;
  logic              out_valid;
  logic [AW-1:0]     x_addr;
  logic [NN*AW-1:0]  w_addr;
  logic [NN*AW-1:0]  b_addr;
  logic [DW-1:0]     x_data = '0;
  logic [NN*DW-1:0]  w_data = '0;
  logic [NN*DW-1:0]  b_data = '0;
  logic [NN*DW-1:0]  out_data;
  logic [1:0]        class_idx;

  logic [DW-1:0]     mem [0:MEMW-1];

  int checks = 0;
  int errors = 0;
  int lat;

  dense_layer_engine #(
    .NUM_NEURONS (NN),
    .NUM_INPUTS  (NI),
    .DATA_W      (DW),
    .FRAC_BITS   (16),
    .ACC_W       (ACCW),
    .ADDR_W      (AW),
    .X_BASE      (XB),
    .W_BASE      (WB),
    .B_BASE      (BB)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .rd_en     (rd_en),
    .x_addr    (x_addr),
    .w_addr    (w_addr),
    .b_addr    (b_addr),
    .x_data    (x_data),
    .w_data    (w_data),
    .b_data    (b_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .class_idx (class_idx)
  );

  always #5 clock = ~clock;

  // Synchronous-read memory: one cycle from address to data on every port.
  always @(posedge clock) begin
    x_data <= mem[x_addr];
    for (int n = 0; n < NN; n++) begin
      w_data[n*DW +: DW] <= mem[w_addr[n*AW +: AW]];
      b_data[n*DW +: DW] <= mem[b_addr[n*AW +: AW]];
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_uniform(input logic [31:0] xv,
                              input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                              input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2);
    for (int i = 0; i < NI; i++) begin
      mem[XB + i]        = xv;
      mem[WB + i]        = w0;
      mem[WB + NI + i]   = w1;
      mem[WB + 2*NI + i] = w2;
    end
    mem[BB]     = b0;
    mem[BB + 1] = b1;
    mem[BB + 2] = b2;
  endtask

  // Drives start for exactly one accepting edge; returns #1 after that edge.
  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Edges counted from the acceptance edge until out_valid is seen (bounded).
  task automatic wait_valid(input int from, output int edges);
    edges = from;
    while (!out_valid && edges < 60) begin
      tick();
      edges++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < MEMW; a++) mem[a] = '0;

    // ---------------- reset state ----------------
    rst = 1'b0;
    tick();
    tick();
    chk("rst_busy",      128'(busy),      128'(0));
    chk("rst_rd_en",     128'(rd_en),     128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data",  128'(out_data),  128'(0));
    chk("rst_class_idx", 128'(class_idx), 128'(0));
    chk("rst_x_addr",    128'(x_addr),    128'(0));
    chk("rst_w_addr",    128'(w_addr),    128'(0));
    chk("rst_b_addr",    128'(b_addr),    128'(0));
    rst = 1'b1;
    tick();

    // ---------------- basic MAC, addressing, latency ----------------
    // out_ready held high throughout: it must not matter before out_valid.
    load_uniform(32'h0001_0000, 32'h0000_8000, 32'hFFFF_0000, 32'h0000_4000,
                 32'h0, 32'h0, 32'h0001_0000);
    out_ready = 1'b1;
    start_run();
    chk("fetch_busy",    128'(busy),              128'(1));
    chk("fetch_rd_en",   128'(rd_en),             128'(1));
    chk("x_addr_k0",     128'(x_addr),            128'(XB));
    chk("w_addr2_k0",    128'(w_addr[2*AW +: AW]), 128'(WB + 8));
    chk("b_addr2",       128'(b_addr[2*AW +: AW]), 128'(BB + 2));
    tick();
    chk("x_addr_k1",     128'(x_addr),            128'(XB + 1));
    chk("w_addr2_k1",    128'(w_addr[2*AW +: AW]), 128'(WB + 9));
    tick();
    tick();
    chk("x_addr_k3",     128'(x_addr),            128'(XB + 3));
    chk("w_addr2_k3",    128'(w_addr[2*AW +: AW]), 128'(WB + 11));
    chk("w_addr0_k3",    128'(w_addr[0 +: AW]),   128'(WB + 3));
    chk("b_addr2_held",  128'(b_addr[2*AW +: AW]), 128'(BB + 2));
    tick();
    chk("drain_rd_en",   128'(rd_en),             128'(0));
    wait_valid(4, lat);
    chk("latency_basic", 128'(lat),               128'(6));
    chk("basic_data",    128'(out_data),          128'(EXP_BASIC));
    chk("basic_idx",     128'(class_idx),         128'(0));
    tick();
    chk("basic_hs_valid", 128'(out_valid),        128'(0));
    chk("basic_hs_busy",  128'(busy),             128'(0));

    // ---------------- saturation + back-pressure ----------------
    load_uniform(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000,
                 32'h0, 32'h0, 32'h0);
    mem[XB + 0] = 32'h7FFF_0000;
    out_ready = 1'b0;
    start_run();
    wait_valid(0, lat);
    chk("latency_sat", 128'(lat),       128'(6));
    chk("sat_data",    128'(out_data),  128'(EXP_SAT));
    chk("sat_idx",     128'(class_idx), 128'(0));
    for (int c = 0; c < 20; c++) begin
      start = (c == 5);
      tick();
      chk("bp_valid", 128'(out_valid), 128'(1));
      chk("bp_data",  128'(out_data),  128'(EXP_SAT));
    end
    start = 1'b0;
    // Handshake and start on the same edge: start must be dropped.
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    chk("bp_release_valid", 128'(out_valid), 128'(0));
    chk("bp_release_busy",  128'(busy),      128'(0));
    tick();
    chk("no_queued_start_busy",  128'(busy),  128'(0));
    chk("no_queued_start_rd_en", 128'(rd_en), 128'(0));

    // ---------------- mixed signs, negative clamp, bias, argmax ----------------
    mem[XB + 0] = 32'h0002_0000;  //  2.0
    mem[XB + 1] = 32'hFFFF_0000;  // -1.0
    mem[XB + 2] = 32'h0000_8000;  //  0.5
    mem[XB + 3] = 32'h0003_0000;  //  3.0
    for (int i = 0; i < NI; i++) begin
      mem[WB + i]      = 32'h0001_0000;            // lane0: 1.0
      mem[WB + NI + i] = 32'h8000_0000;            // lane1: -32768.0
    end
    mem[WB + 2*NI + 0] = 32'h0001_0000;
    mem[WB + 2*NI + 1] = 32'h0001_0000;
    mem[WB + 2*NI + 2] = 32'h0002_0000;
    mem[WB + 2*NI + 3] = 32'h0002_0000;
    mem[BB]     = 32'h0;
    mem[BB + 1] = 32'h0;
    mem[BB + 2] = 32'hFFFE_8000;                   // -1.5
    out_ready = 1'b1;
    start_run();
    wait_valid(0, lat);
    chk("latency_mix", 128'(lat),       128'(6));
    chk("mix_data",    128'(out_data),  128'(EXP_MIX));
    chk("mix_idx",     128'(class_idx), 128'(EXP_MIX_IDX));
    tick();
    chk("mix_hs_valid", 128'(out_valid), 128'(0));

    // ---------------- reset in the middle of FETCH ----------------
    start_run();
    tick();
    tick();
    chk("abort_at_k2", 128'(x_addr), 128'(XB + 2));
    rst = 1'b0;
    tick();
    chk("abort_busy",      128'(busy),      128'(0));
    chk("abort_rd_en",     128'(rd_en),     128'(0));
    chk("abort_out_valid", 128'(out_valid), 128'(0));
    chk("abort_out_data",  128'(out_data),  128'(0));
    rst = 1'b1;
    tick();
    start_run();
    wait_valid(0, lat);
    chk("latency_rerun", 128'(lat),       128'(6));
    chk("rerun_data",    128'(out_data),  128'(EXP_MIX));
    chk("rerun_idx",     128'(class_idx), 128'(EXP_MIX_IDX));
    tick();
    chk("rerun_hs_busy", 128'(busy), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
